imem_scan_ctrl: RTL and testbench

Sequencer that walks instruction memory over a programmed word range and drives iaddr to imem. It samples the 3-bit code from errordetect for each fetched word, then logs the error count, the first faulting address and the first faulting code. It sits between a host/test controller (start/done handshake) and the imem + errordetect pair. This replaces free-running address increment with a bounded, abortable, optionally halting scan.

---
 rtl/imem_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_imem_scan_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_scan_ctrl.sv
// Bounded, abortable instruction-memory scanner that logs errordetect codes.
// Optional per-code histogram enabled by defining IMEM_SCAN_HIST_EN.
module imem_scan_ctrl #(
  parameter int CNT_W = 16,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             halt_on_err,
  input  logic [31:0]      base_addr,
  input  logic [31:0]      limit_addr,
  input  logic [2:0]       error,
  output logic [31:0]      iaddr,
  output logic             busy,
  output logic             done,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count,
  output logic [31:0]      first_err_addr,
  output logic [2:0]       first_err_code,
  input  logic [2:0]       hist_sel,
  output logic [CNT_W-1:0] hist_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      iaddr_q, iaddr_d;
  logic [31:0]      limit_q, limit_d;
  logic [31:0]      firstErrAddr_q, firstErrAddr_d;
  logic [2:0]       firstErrCode_q, firstErrCode_d;
  logic             errFlag_q, errFlag_d;
  logic [CNT_W-1:0] errCount_q, errCount_d;
  logic             halt_q, halt_d;
  logic             histClear, histLog;

  logic [31:0] baseMasked, limitMasked;
  logic        errSeen;

  assign baseMasked  = {base_addr[31:2], 2'b00};
  assign limitMasked = {limit_addr[31:2], 2'b00};
  assign errSeen     = (error != 3'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      iaddr_q        <= '0;
      limit_q        <= '0;
      firstErrAddr_q <= '0;
      firstErrCode_q <= '0;
      errFlag_q      <= 1'b0;
      errCount_q     <= '0;
      halt_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      iaddr_q        <= iaddr_d;
      limit_q        <= limit_d;
      firstErrAddr_q <= firstErrAddr_d;
      firstErrCode_q <= firstErrCode_d;
      errFlag_q      <= errFlag_d;
      errCount_q     <= errCount_d;
      halt_q         <= halt_d;
    end
  end

  // The limit is latched at start so a changing input cannot skip the end-of-range match.
  always_comb begin
    state_d        = state_q;
    iaddr_d        = iaddr_q;
    limit_d        = limit_q;
    firstErrAddr_d = firstErrAddr_q;
    firstErrCode_d = firstErrCode_q;
    errFlag_d      = errFlag_q;
    errCount_d     = errCount_q;
    halt_d         = halt_q;
    histClear      = 1'b0;
    histLog        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          histClear  = 1'b1;
          errFlag_d  = 1'b0;
          errCount_d = '0;
          if (baseMasked > limitMasked) begin
            state_d = DONE;
          end else begin
            iaddr_d        = baseMasked;
            limit_d        = limitMasked;
            firstErrAddr_d = '0;
            firstErrCode_d = '0;
            halt_d         = halt_on_err;
            state_d        = SCAN;
          end
        end
      end
      SCAN: begin
        histLog = 1'b1;
        if (errSeen) begin
          if (errCount_q != {CNT_W{1'b1}}) errCount_d = errCount_q + CNT_W'(1);
          if (!errFlag_q) begin
            firstErrAddr_d = iaddr_q;
            firstErrCode_d = error;
            errFlag_d      = 1'b1;
          end
        end
        if (abort || (halt_q && errSeen) || (iaddr_q == limit_q)) begin
          state_d = DONE;
        end else begin
          iaddr_d = iaddr_q + 32'(STEP);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign iaddr          = iaddr_q;
  assign busy           = (state_q == SCAN);
  assign done           = (state_q == DONE);
  assign err_flag       = errFlag_q;
  assign err_count      = errCount_q;
  assign first_err_addr = firstErrAddr_q;
  assign first_err_code = firstErrCode_q;

`ifdef IMEM_SCAN_HIST_EN
  logic [CNT_W-1:0] hist_q [1:7];
  logic             unusedAddrBits;

  assign unusedAddrBits = ^{base_addr[1:0], limit_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!reset || histClear) begin
      for (int c = 1; c <= 7; c++) hist_q[c] <= '0;
    end else if (histLog) begin
      for (int c = 1; c <= 7; c++) begin
        if ((error == 3'(c)) && (hist_q[c] != {CNT_W{1'b1}})) hist_q[c] <= hist_q[c] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    hist_count = '0;
    if (hist_sel != 3'd0) hist_count = hist_q[hist_sel];
  end
`else
  logic unusedAddrBits;

  assign unusedAddrBits = ^{base_addr[1:0], limit_addr[1:0], hist_sel, histClear, histLog};
  assign hist_count     = '0;
`endif

endmodule

// File: tb/tb_imem_scan_ctrl.sv
// Directed bench for imem_scan_ctrl: a scan-level model predicts the address
// sequence and logged results; a second instance with CNT_W=4 checks saturation.
module tb_imem_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        halt_on_err = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] limit_addr = '0;
  logic [2:0]  errorIn;
  logic [2:0]  hist_sel = 3'd0;
  int          imageMode = 0;

  logic [31:0] iaddr, satIaddr;
  logic        busy, done, err_flag, satBusy, satDone, satFlag;
  logic [15:0] err_count, hist_count;
  logic [3:0]  satCount, satHist;
  logic [31:0] first_err_addr, satFirstAddr;
  logic [2:0]  first_err_code, satFirstCode;

  int total = 0;
  int bad = 0;
  logic [31:0] holdIaddr = '0;

  always #5 clk = ~clk;

  imem_scan_ctrl #(.CNT_W(16), .STEP(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .halt_on_err(halt_on_err),
    .base_addr(base_addr), .limit_addr(limit_addr), .error(errorIn), .iaddr(iaddr),
    .busy(busy), .done(done), .err_flag(err_flag), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_code(first_err_code),
    .hist_sel(hist_sel), .hist_count(hist_count)
  );

  imem_scan_ctrl #(.CNT_W(4), .STEP(4)) dutSat (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .halt_on_err(halt_on_err),
    .base_addr(base_addr), .limit_addr(limit_addr), .error(errorIn), .iaddr(satIaddr),
    .busy(satBusy), .done(satDone), .err_flag(satFlag), .err_count(satCount),
    .first_err_addr(satFirstAddr), .first_err_code(satFirstCode),
    .hist_sel(hist_sel), .hist_count(satHist)
  );

  // Memory image: 0 all clean, 1 faults at 0x10/0x24, 2 every word faulty.
  function automatic logic [2:0] errOf(input int mode, input logic [31:0] a);
    errOf = 3'd0;
    if (mode == 1 && a == 32'h10) errOf = 3'd3;
    if (mode == 1 && a == 32'h24) errOf = 3'd5;
    if (mode == 2) errOf = 3'd7;
  endfunction

  always_comb errorIn = errOf(imageMode, iaddr);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rstIaddr", iaddr, 32'h0);
    checkOutput("rstBusy", {31'b0, busy}, 32'h0);
    checkOutput("rstDone", {31'b0, done}, 32'h0);
    checkOutput("rstFlag", {31'b0, err_flag}, 32'h0);
    checkOutput("rstCount", {16'b0, err_count}, 32'h0);
    checkOutput("rstFirstAddr", first_err_addr, 32'h0);
    checkOutput("rstFirstCode", {29'b0, first_err_code}, 32'h0);
    reset = 1'b1;
    holdIaddr = '0;
    @(negedge clk);
    checkOutput("rstIdle", {31'b0, busy}, 32'h0);
  endtask

  // Predicts the scan from the address/error rules, then drives and checks it cycle by cycle.
  task automatic applyStimulus(input logic [31:0] b, input logic [31:0] l, input logic h,
                               input int mode, input logic abEn, input logic [31:0] abAt,
                               input logic pulseStart);
    logic [31:0] expAddr[$];
    logic [31:0] a, bM, lM, fa;
    logic [2:0]  e, fc;
    int          cnt, hist[8];
    logic        flag;
    bM = b & ~32'h3;
    lM = l & ~32'h3;
    cnt = 0; flag = 0; fa = 0; fc = 0;
    for (int k = 0; k < 8; k++) hist[k] = 0;
    if (bM <= lM) begin
      a = bM;
      for (int guard = 0; guard < 1000; guard++) begin
        e = errOf(mode, a);
        expAddr.push_back(a);
        if (e != 0) begin
          cnt++;
          hist[e]++;
          if (!flag) begin fa = a; fc = e; flag = 1; end
        end
        if (abEn && a == abAt) break;
        if (h && e != 0) break;
        if (a == lM) break;
        a = a + 32'd4;
      end
    end

    @(negedge clk);
    imageMode = mode;
    base_addr = b; limit_addr = l; halt_on_err = h; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    foreach (expAddr[i]) begin
      @(negedge clk);
      checkOutput("scanBusy", {31'b0, busy}, 32'h1);
      checkOutput("scanIaddr", iaddr, expAddr[i]);
      checkOutput("scanDone", {31'b0, done}, 32'h0);
      start = pulseStart && (i == 2);
      abort = abEn && (expAddr[i] == abAt);
    end

    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    if (expAddr.size() > 0) holdIaddr = expAddr[expAddr.size()-1];
    checkOutput("endDone", {31'b0, done}, 32'h1);
    checkOutput("endBusy", {31'b0, busy}, 32'h0);
    checkOutput("endIaddr", iaddr, holdIaddr);
    checkOutput("endCount", {16'b0, err_count}, cnt);
    checkOutput("endFlag", {31'b0, err_flag}, {31'b0, flag});
    checkOutput("satCount", {28'b0, satCount}, (cnt > 15) ? 15 : cnt);
    if (expAddr.size() > 0) begin
      checkOutput("endFirstAddr", first_err_addr, fa);
      checkOutput("endFirstCode", {29'b0, first_err_code}, {29'b0, fc});
      for (int s = 3; s <= 5; s += 2) begin
        hist_sel = 3'(s);
        #1;
`ifdef IMEM_SCAN_HIST_EN
        checkOutput("histCount", {16'b0, hist_count}, hist[s]);
`else
        checkOutput("histCount", {16'b0, hist_count}, 32'h0);
`endif
      end
      hist_sel = 3'd0;
    end
    @(negedge clk);
    checkOutput("doneOnePulse", {31'b0, done}, 32'h0);
    checkOutput("idleBusy", {31'b0, busy}, 32'h0);
    checkOutput("holdCount", {16'b0, err_count}, cnt);
    checkOutput("holdIaddr", iaddr, holdIaddr);
  endtask

  initial begin
    $display("[TB] starting imem_scan_ctrl bench");
    doReset();

    applyStimulus(32'h0, 32'h3C, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    checkOutput("cleanCountLit", {16'b0, err_count}, 32'h0);
    checkOutput("cleanIaddrLit", iaddr, 32'h3C);

    applyStimulus(32'h0, 32'h3C, 1'b0, 1, 1'b0, 32'h0, 1'b0);
    checkOutput("injCountLit", {16'b0, err_count}, 32'h2);
    checkOutput("injFirstAddrLit", first_err_addr, 32'h10);
    checkOutput("injFirstCodeLit", {29'b0, first_err_code}, 32'h3);
    checkOutput("injFlagLit", {31'b0, err_flag}, 32'h1);

    applyStimulus(32'h0, 32'h3C, 1'b1, 1, 1'b0, 32'h0, 1'b0);
    checkOutput("haltIaddrLit", iaddr, 32'h10);
    checkOutput("haltCountLit", {16'b0, err_count}, 32'h1);
    halt_on_err = 1'b0;

    applyStimulus(32'h20, 32'h10, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'h8, 32'h8, 1'b0, 1, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'hFFFFFFF8, 32'hFFFFFFFF, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    checkOutput("wrapIaddrLit", iaddr, 32'hFFFFFFFC);

    applyStimulus(32'h0, 32'h3C, 1'b0, 1, 1'b1, 32'h8, 1'b0);
    checkOutput("abortIaddrLit", iaddr, 32'h8);

    applyStimulus(32'h0, 32'h3C, 1'b0, 1, 1'b0, 32'h0, 1'b1);

    applyStimulus(32'h0, 32'h4C, 1'b0, 2, 1'b0, 32'h0, 1'b0);
    checkOutput("satLit", {28'b0, satCount}, 32'd15);
    checkOutput("satWideLit", {16'b0, err_count}, 32'd20);

    // Reset in the middle of a scan, after the first fault has been logged.
    @(negedge clk);
    imageMode = 1;
    base_addr = 32'h0; limit_addr = 32'h3C; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(negedge clk);
    doReset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
